// File: rtl/sar_adc_ctrl_if.sv
// sar_adc_ctrl_if
//   Signal bundle between the SAR sequencer, the digital host and the analog
//   core. The clock (cp) and reset (cdn) stay outside the bundle.
//
//   Host side    : start (request), busy, valid, dout (result)
//   Analog side  : sample (track switch), dac_code (trial code), cmp (decision)
//
//   Modports
//     master : host + analog core view (drives start and cmp)
//     slave  : sequencer view (drives sample, dac_code, busy, valid, dout)
//
//   Handshake: start is a level request that is only looked at while the
//   sequencer is idle (busy=0); a high start on such an edge launches exactly
//   one conversion and is otherwise ignored, never queued. valid is a
//   single-cycle strobe with no back-pressure: dout is new in the cycle valid
//   is high and holds until the next completion.
interface sar_adc_ctrl_if #(
   parameter int NBITS = 8
);
   logic             start;
   logic             cmp;
   logic             sample;
   logic [NBITS-1:0] dac_code;
   logic             busy;
   logic             valid;
   logic [NBITS-1:0] dout;

   modport master (
      output start,
      output cmp,
      input  sample,
      input  dac_code,
      input  busy,
      input  valid,
      input  dout
   );

   modport slave (
      input  start,
      input  cmp,
      output sample,
      output dac_code,
      output busy,
      output valid,
      output dout
   );
endinterface

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl
//   Successive-approximation sequencer for the SAR ADC macro. Holds the
//   sample switch closed for SAMPLE_CYCLES, then walks the capacitive-DAC
//   trial code from MSB to LSB, letting the DAC settle for SETTLE_CYCLES
//   before each comparator decision. The final code is published on dout
//   with a one-cycle valid strobe.
//
//   Parameters
//     NBITS         : resolution, 2..16
//     SAMPLE_CYCLES : cycles the sample switch stays closed, 1..15
//     SETTLE_CYCLES : DAC settling cycles before each compare, 0..15
//
//   Ports
//     cp        : clock, rising edge
//     cdn       : asynchronous active-low reset
//     bus       : sar_adc_ctrl_if.slave (start, cmp in; sample, dac_code,
//                 busy, valid, dout out; all outputs registered)
//     state_dbg : current FSM state (IDLE=0, SAMPLE=1, SETTLE=2,
//                 COMPARE=3, DONE=4)
module sar_adc_ctrl #(
   parameter int NBITS         = 8,
   parameter int SAMPLE_CYCLES = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 cp,
   input  logic                 cdn,
   sar_adc_ctrl_if.slave        bus,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAMPLE  = 3'd1,
      SETTLE  = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

   // Counter reload values are "cycles - 1" so that a phase ends on the
   // edge where the counter is already zero.
   localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_CYCLES - 1);
   localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

   // With no settling time every trial goes straight to the compare.
   localparam state_t TRIAL_STATE = (SETTLE_CYCLES > 0) ? SETTLE : COMPARE;

   localparam logic [NBITS-1:0] ONE      = NBITS'(1);
   localparam logic [NBITS-1:0] MSB_CODE = ONE << (NBITS - 1);

   state_t               state;
   logic [3:0]           cnt;
   logic [IDX_W-1:0]     idx;
   logic                 sample_r;
   logic [NBITS-1:0]     dac_r;
   logic                 busy_r;
   logic                 valid_r;
   logic [NBITS-1:0]     dout_r;

   // Trial-bit arithmetic for the compare edge. The bit under test is
   // always 1 in dac_r, so deciding it only ever needs a clear. The next
   // trial bit sits one position lower; at idx=0 the shifted mask is empty.
   logic [NBITS-1:0]     bit_mask;
   logic [NBITS-1:0]     decided;
   logic [NBITS-1:0]     next_trial;

   always_comb begin
      bit_mask   = ONE << idx;
      decided    = bus.cmp ? dac_r : (dac_r & ~bit_mask);
      next_trial = decided | (bit_mask >> 1);
   end

   always_ff @(posedge cp or negedge cdn) begin
      if (!cdn) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         idx      <= '0;
         sample_r <= 1'b0;
         dac_r    <= '0;
         busy_r   <= 1'b0;
         valid_r  <= 1'b0;
         dout_r   <= '0;
      end else begin
         case (state)
            IDLE: begin
               valid_r <= 1'b0;
               if (bus.start) begin
                  state    <= SAMPLE;
                  sample_r <= 1'b1;
                  busy_r   <= 1'b1;
                  cnt      <= SAMPLE_LOAD;
               end
            end

            SAMPLE: begin
               if (cnt == 4'd0) begin
                  // Track phase over: open the switch and present the MSB trial.
                  sample_r <= 1'b0;
                  idx      <= IDX_W'(NBITS - 1);
                  dac_r    <= MSB_CODE;
                  cnt      <= SETTLE_LOAD;
                  state    <= TRIAL_STATE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            SETTLE: begin
               if (cnt == 4'd0) begin
                  state <= COMPARE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            COMPARE: begin
               if (idx != '0) begin
                  dac_r <= next_trial;
                  idx   <= idx - 1'b1;
                  cnt   <= SETTLE_LOAD;
                  state <= TRIAL_STATE;
               end else begin
                  dac_r   <= decided;
                  dout_r  <= decided;
                  valid_r <= 1'b1;
                  state   <= DONE;
               end
            end

            DONE: begin
               valid_r <= 1'b0;
               dac_r   <= '0;
               busy_r  <= 1'b0;
               state   <= IDLE;
            end

            default: begin
               state    <= IDLE;
               sample_r <= 1'b0;
               dac_r    <= '0;
               busy_r   <= 1'b0;
               valid_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sample   = sample_r;
   assign bus.dac_code = dac_r;
   assign bus.busy     = busy_r;
   assign bus.valid    = valid_r;
   assign bus.dout     = dout_r;
   assign state_dbg    = state;

endmodule
